// File: rtl/gin_pkg.sv
// Shared definitions for the GIN initiator: state encoding and size helpers.
package gin_pkg;

    localparam int unsigned BITWIDTH_DEF        = 16;
    localparam int unsigned TAG_LENGTH_DEF      = 4;
    localparam int unsigned X_BUS_SIZE_DEF      = 4;
    localparam int unsigned Y_BUS_SIZE_DEF      = 4;
    localparam int unsigned INPUT_PACKET_LENGTH = 2 * TAG_LENGTH_DEF + BITWIDTH_DEF;

    typedef enum logic [1:0] {
        ST_UNPROG  = 2'd0,
        ST_PROGRAM = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // One tag per X-bus on the Y-bus, then one tag per PE.
    function automatic int unsigned scan_len(input int unsigned y_bus, input int unsigned x_bus);
        return y_bus + y_bus * x_bus;
    endfunction

    function automatic int unsigned packet_len(input int unsigned tag_len, input int unsigned bitwidth);
        return 2 * tag_len + bitwidth;
    endfunction

endpackage

// File: rtl/gin_sender_fifo.sv
// Packet FIFO with a registered head word and registered full/empty flags.
module gin_sender_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rstb_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             full_next_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // The head register tracks whichever entry will sit at the read pointer next cycle.
    always_comb begin
        do_push = push_i && !full_q;
        do_pop  = pop_i && !empty_q;
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        head_d  = head_q;
        if (count_d != '0) begin
            if (do_push && (wr_q == rd_d)) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign head_o      = head_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign full_next_o = (count_d == CW'(DEPTH));

endmodule

// File: rtl/gin_sender.sv
// GIN initiator: loads the scan chain with tag IDs, then streams tagged packets through a FIFO.
module gin_sender
    import gin_pkg::*;
#(
    parameter int unsigned BITWIDTH   = 16,
    parameter int unsigned TAG_LENGTH = 4,
    parameter int unsigned X_BUS_SIZE = 4,
    parameter int unsigned Y_BUS_SIZE = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rstb_i,
    input  logic                             start_program_i,
    input  logic                             cfg_valid_i,
    output logic                             cfg_ready_o,
    input  logic [TAG_LENGTH-1:0]            cfg_tag_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [TAG_LENGTH-1:0]            in_row_tag_i,
    input  logic [TAG_LENGTH-1:0]            in_col_tag_i,
    input  logic [BITWIDTH-1:0]              in_data_i,
    output logic                             program_o,
    output logic [TAG_LENGTH-1:0]            scan_tag_out_o,
    output logic                             gin_enable_o,
    input  logic                             gin_ready_i,
    output logic [2*TAG_LENGTH+BITWIDTH-1:0] data_packet_o,
    output logic                             programmed_o
);

    localparam int unsigned PKT_W    = packet_len(TAG_LENGTH, BITWIDTH);
    localparam int unsigned SCAN_LEN = scan_len(Y_BUS_SIZE, X_BUS_SIZE);
    localparam int unsigned CNT_W    = $clog2(SCAN_LEN + 1);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  pending_q, pending_d;
    logic                  program_q, cfg_ready_q, in_ready_q, programmed_q;
    logic [TAG_LENGTH-1:0] scan_tag_q;
    logic                  fifo_full, fifo_empty, fifo_full_next;
    logic                  push, pop, cfg_accept;
    logic [PKT_W-1:0]      head;

    assign cfg_accept = cfg_valid_i && cfg_ready_q;
    assign push       = in_valid_i && in_ready_q && !fifo_full;
    assign pop        = !fifo_empty && gin_ready_i;
    assign pending_d  = pending_q || start_program_i;

    gin_sender_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstb_i      (rstb_i),
        .push_i      (push),
        .wdata_i     ({in_row_tag_i, in_col_tag_i, in_data_i}),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .full_next_o (fifo_full_next)
    );

    // Phase sequencing with registered handshake and scan outputs.
    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            state_q      <= ST_UNPROG;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            program_q    <= 1'b0;
            scan_tag_q   <= '0;
            cfg_ready_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            programmed_q <= 1'b0;
        end else begin
            program_q <= 1'b0;
            unique case (state_q)
                ST_UNPROG: begin
                    if (start_program_i) begin
                        state_q      <= ST_PROGRAM;
                        cnt_q        <= '0;
                        programmed_q <= 1'b0;
                        cfg_ready_q  <= 1'b1;
                    end
                end
                ST_PROGRAM: begin
                    if (cfg_accept) begin
                        program_q  <= 1'b1;
                        scan_tag_q <= cfg_tag_i;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(SCAN_LEN - 1)) begin
                            state_q      <= ST_RUN;
                            programmed_q <= 1'b1;
                            cfg_ready_q  <= 1'b0;
                            in_ready_q   <= !fifo_full_next;
                        end
                    end
                end
                ST_RUN: begin
                    // Pending reprogram waits until the GIN has taken every queued packet.
                    if (pending_q && fifo_empty) begin
                        state_q      <= ST_PROGRAM;
                        pending_q    <= 1'b0;
                        cnt_q        <= '0;
                        programmed_q <= 1'b0;
                        cfg_ready_q  <= 1'b1;
                        in_ready_q   <= 1'b0;
                    end else begin
                        pending_q  <= pending_d;
                        in_ready_q <= !pending_d && !fifo_full_next;
                    end
                end
                default: begin
                    state_q     <= ST_UNPROG;
                    cfg_ready_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign program_o      = program_q;
    assign scan_tag_out_o = scan_tag_q;
    assign cfg_ready_o    = cfg_ready_q;
    assign in_ready_o     = in_ready_q;
    assign programmed_o   = programmed_q;
    assign gin_enable_o   = !fifo_empty;
    assign data_packet_o  = head;

endmodule

// File: tb/tb_gin_sender.sv
// Self-checking bench for gin_sender: vector table, directed corner cases and a random run vs a queue model.
module tb_gin_sender;

    localparam int unsigned BW    = 16;
    localparam int unsigned TL    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SCAN  = 20;
    localparam int unsigned PW    = 2 * TL + BW;

    logic          clk = 1'b0;
    logic          rstb, start_program, cfg_valid, in_valid, gin_ready;
    logic [TL-1:0] cfg_tag, in_row_tag, in_col_tag;
    logic [BW-1:0] in_data;
    logic          cfg_ready, in_ready, program_o, gin_enable, programmed;
    logic [TL-1:0] scan_tag_out;
    logic [PW-1:0] data_packet;

    gin_sender #(
        .BITWIDTH(BW), .TAG_LENGTH(TL), .X_BUS_SIZE(4), .Y_BUS_SIZE(4), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i           (clk),
        .rstb_i          (rstb),
        .start_program_i (start_program),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_tag_i       (cfg_tag),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_row_tag_i    (in_row_tag),
        .in_col_tag_i    (in_col_tag),
        .in_data_i       (in_data),
        .program_o       (program_o),
        .scan_tag_out_o  (scan_tag_out),
        .gin_enable_o    (gin_enable),
        .gin_ready_i     (gin_ready),
        .data_packet_o   (data_packet),
        .programmed_o    (programmed)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 = unprogrammed, 1 = loading chain, 2 = streaming.
    int            m_phase, m_cnt;
    bit            m_pend, m_programmed, m_prog;
    logic [TL-1:0] m_tag;
    logic [PW-1:0] m_q[$];
    logic [PW-1:0] xfers[$];
    logic [TL-1:0] chain[$];

    logic [TL-1:0] tags [20] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2,
                                 4'd3, 4'd4, 4'd2, 4'd3, 4'd4, 4'd5, 4'd3, 4'd4, 4'd5, 4'd6};

    typedef struct {
        bit            start;
        bit            cv;
        logic [TL-1:0] tag;
        bit            e_prog;
        logic [TL-1:0] e_tag;
        bit            e_cfg_rdy;
        bit            e_progd;
    } vec_t;
    vec_t vec[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
        return (m_phase == 2) && !m_pend && (m_q.size() < DEPTH);
    endfunction

    task automatic model_advance();
        bit acc_in, do_pop;
        acc_in = in_valid && m_in_ready();
        do_pop = (m_q.size() > 0) && gin_ready;
        if (!rstb) begin
            m_phase = 0; m_cnt = 0; m_pend = 0; m_programmed = 0; m_prog = 0; m_tag = '0;
            m_q.delete();
        end else begin
            m_prog = 0;
            case (m_phase)
                0: if (start_program) begin m_phase = 1; m_cnt = 0; m_programmed = 0; end
                1: if (cfg_valid) begin
                    m_prog = 1; m_tag = cfg_tag; m_cnt++;
                    if (m_cnt == SCAN) begin m_phase = 2; m_programmed = 1; end
                end
                2: begin
                    if (m_pend && m_q.size() == 0) begin
                        m_phase = 1; m_pend = 0; m_cnt = 0; m_programmed = 0;
                    end else begin
                        if (start_program) m_pend = 1;
                        if (do_pop) void'(m_q.pop_front());
                        if (acc_in) m_q.push_back({in_row_tag, in_col_tag, in_data});
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Apply staged inputs for one clock, advance the model, then compare at the falling edge.
    task automatic step();
        bit rst_edge;
        rst_edge = !rstb;
        if (gin_enable === 1'b1 && gin_ready) xfers.push_back(data_packet);
        model_advance();
        @(posedge clk);
        @(negedge clk);
        if (program_o === 1'b1) chain.push_back(scan_tag_out);
        check("cfg_ready", 32'(cfg_ready), 32'(m_phase == 1));
        check("in_ready", 32'(in_ready), 32'(m_in_ready()));
        check("gin_enable", 32'(gin_enable), 32'(m_q.size() > 0));
        check("program", 32'(program_o), 32'(m_prog));
        check("programmed", 32'(programmed), 32'(m_programmed));
        if (m_prog || rst_edge) check("scan_tag_out", 32'(scan_tag_out), 32'(m_tag));
        if (m_q.size() > 0) check("data_packet", 32'(data_packet), 32'(m_q[0]));
        else if (rst_edge) check("data_packet_rst", 32'(data_packet), 32'd0);
    endtask

    task automatic idle_inputs();
        rstb = 1'b1; start_program = 1'b0; cfg_valid = 1'b0; cfg_tag = '0;
        in_valid = 1'b0; in_row_tag = '0; in_col_tag = '0; in_data = '0; gin_ready = 1'b1;
    endtask

    task automatic add(input bit s, input bit cv, input logic [TL-1:0] t, input bit ep,
                       input logic [TL-1:0] et, input bit ecr, input bit epd);
        vec.push_back('{s, cv, t, ep, et, ecr, epd});
    endtask

    initial begin
        logic [PW-1:0] offered[$];
        int col;

        // Two programming passes: continuous, then a reprogram with a 3-cycle source stall after word 7.
        add(1, 0, 4'd0, 0, 4'd0, 1, 0);
        for (int i = 0; i < 20; i++) add(0, 1, tags[i], 1, tags[i], i < 19, i == 19);
        add(0, 1, 4'hF, 0, 4'd0, 0, 1);
        add(1, 0, 4'd0, 0, 4'd0, 0, 1);
        add(0, 0, 4'd0, 0, 4'd0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            add(0, 1, tags[i], 1, tags[i], i < 19, i == 19);
            if (i == 7) for (int k = 0; k < 3; k++) add(0, 0, 4'd0, 0, 4'd0, 1, 0);
        end
        add(0, 0, 4'd0, 0, 4'd0, 0, 1);

        idle_inputs();
        rstb = 1'b0;
        @(negedge clk);
        step();
        step();
        rstb = 1'b1;
        step();

        chain.delete();
        for (int i = 0; i < vec.size(); i++) begin
            start_program = vec[i].start; cfg_valid = vec[i].cv; cfg_tag = vec[i].tag;
            step();
            check("vec_program", 32'(program_o), 32'(vec[i].e_prog));
            check("vec_cfg_ready", 32'(cfg_ready), 32'(vec[i].e_cfg_rdy));
            check("vec_programmed", 32'(programmed), 32'(vec[i].e_progd));
            if (vec[i].e_prog) check("vec_scan_tag", 32'(scan_tag_out), 32'(vec[i].e_tag));
        end
        idle_inputs();
        check("chain_len", 32'(chain.size()), 32'd40);
        for (int i = 0; i < chain.size() && i < 40; i++) check("chain_tag", 32'(chain[i]), 32'(tags[i % 20]));

        // Back-to-back burst row 0 col 0..6 with the GIN always ready.
        xfers.delete();
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1; in_row_tag = '0; in_col_tag = TL'(c); in_data = 16'hFFFF;
            step();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) step();
        check("burst_count", 32'(xfers.size()), 32'd7);
        for (int c = 0; c < xfers.size() && c < 7; c++)
            check("burst_pkt", 32'(xfers[c]), 32'({4'd0, 4'(c), 16'hFFFF}));

        // GIN stalls for 6 cycles while packets are offered; FIFO fills, then drains in order.
        xfers.delete();
        offered.delete();
        col = 8;
        gin_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_row_tag = 4'd1; in_col_tag = TL'(col); in_data = BW'($urandom);
            if (m_in_ready()) begin
                offered.push_back({in_row_tag, in_col_tag, in_data});
                col++;
            end
            step();
        end
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_offered", 32'(offered.size()), 32'd4);
        idle_inputs();
        for (int k = 0; k < 6; k++) step();
        check("drain_count", 32'(xfers.size()), 32'd4);
        for (int i = 0; i < xfers.size() && i < offered.size(); i++)
            check("drain_pkt", 32'(xfers[i]), 32'(offered[i]));

        // Reprogram request with 3 packets queued.
        xfers.delete();
        gin_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_row_tag = 4'd2; in_col_tag = TL'(k); in_data = BW'(16'h1230 + k);
            step();
        end
        in_valid = 1'b0;
        start_program = 1'b1;
        step();
        start_program = 1'b0;
        check("pend_in_ready", 32'(in_ready), 32'd0);
        gin_ready = 1'b1;
        for (int k = 0; k < 20 && cfg_ready !== 1'b1; k++) step();
        check("pend_cfg_ready", 32'(cfg_ready), 32'd1);
        check("pend_xfers", 32'(xfers.size()), 32'd3);

        // Reset after 9 shifted tags, then a clean full program.
        for (int i = 0; i < 9; i++) begin
            cfg_valid = 1'b1; cfg_tag = tags[i];
            step();
        end
        cfg_valid = 1'b0;
        rstb = 1'b0;
        step();
        check("rst_outputs", 32'({program_o, cfg_ready, in_ready, gin_enable, programmed}), 32'd0);
        check("rst_data", 32'(data_packet), 32'd0);
        rstb = 1'b1;
        start_program = 1'b1;
        step();
        start_program = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cfg_valid = 1'b1; cfg_tag = tags[i];
            step();
        end
        cfg_valid = 1'b0;
        step();
        check("reprog_done", 32'(programmed), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rstb          = ($urandom_range(999) != 0);
            start_program = ($urandom_range(63) == 0);
            cfg_valid     = ($urandom_range(3) != 0);
            cfg_tag       = TL'($urandom);
            in_valid      = $urandom_range(1) == 1;
            in_row_tag    = TL'($urandom);
            in_col_tag    = TL'($urandom);
            in_data       = BW'($urandom);
            gin_ready     = ($urandom_range(9) < 7);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gin_sender.md
# gin_sender

Initiator-side driver for the global input network (`gin`). It runs in two phases. First it programs the GIN scan chain by shifting in all Y-bus and X-bus tag IDs. It then streams tagged data packets `{row_tag, col_tag, data}` into the GIN using the `gin_enable`/`gin_ready` handshake, buffering them in a small FIFO. It sits between the global buffer/controller and the `gin` instance, and replaces hand-driven stimulus with synthesizable sequencing.

## Interface
Parameters:
- `BITWIDTH`, 16, payload width.
- `TAG_LENGTH`, 4, width of a row or column tag.
- `X_BUS_SIZE`, 4, PEs per X-bus.
- `Y_BUS_SIZE`, 4, number of X-buses.
- `FIFO_DEPTH`, 4, packet FIFO entries (power of 2, ≥2).

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `rstb` in 1: reset, synchronous, active-low.
- `start_program` in 1: single-cycle request to (re)program the scan chain.
- `cfg_valid` in 1, `cfg_ready` out 1, `cfg_tag` in TAG_LENGTH: scan-tag stream, ordered Y-bus tags first, then X-bus tags.
- `in_valid` in 1, `in_ready` out 1: packet input handshake.
- `in_row_tag` in TAG_LENGTH, `in_col_tag` in TAG_LENGTH, `in_data` in BITWIDTH: packet fields.
- `program` out 1: scan-chain shift enable to GIN.
- `scan_tag_out` out TAG_LENGTH: tag presented to GIN `scan_tag_in`.
- `gin_enable` out 1: packet valid to GIN.
- `gin_ready` in 1: GIN ready to accept.
- `data_packet` out 2*TAG_LENGTH+BITWIDTH: packet to GIN.
- `programmed` out 1: scan chain fully loaded since the last programming request.

## Operation
- `SCAN_LEN = Y_BUS_SIZE + Y_BUS_SIZE*X_BUS_SIZE` (20 at defaults).
- States:
  - **UNPROG** (reset state).
  - **PROGRAM**.
  - **RUN**.
- **UNPROG → PROGRAM** on `start_program`. Clears `programmed` and the shift counter.
- **PROGRAM**:
  - `cfg_ready`=1.
  - Each accepted `cfg_tag` produces exactly one cycle of `program`=1 with `scan_tag_out`=that tag.
  - No accepted word means `program`=0 that cycle. The GIN holds its chain, so source stalls are safe.
  - Counter increments per accepted word. When the accepted word is the `SCAN_LEN`-th, go to RUN and set `programmed`=1.
- **RUN**:
  - `in_ready` = FIFO not full and no pending program request.
  - Accepted inputs are pushed into the FIFO as `{row_tag, col_tag, data}`.
  - FIFO head drives `data_packet`; `gin_enable` = FIFO not empty.
  - Transfer occurs when `gin_enable && gin_ready`, which pops the head.
- `start_program` in RUN sets a sticky pending flag.
  - `in_ready` drops the next cycle.
  - PROGRAM is entered in the cycle after the FIFO is empty and no transfer is outstanding.
- `start_program` in PROGRAM is ignored.
- `cfg_ready`=0 outside PROGRAM.
- `in_ready`=0 outside RUN.

## Timing
- Reset values: `program`=0, `scan_tag_out`=0, `gin_enable`=0, `data_packet`=0, `cfg_ready`=0, `in_ready`=0, `programmed`=0. State = UNPROG, FIFO empty, counter=0, pending=0.
- `program` and `scan_tag_out` are registered: word accepted at edge N appears N→N+1.
- Input packet accepted at edge N: `gin_enable`=1 with that packet from N+1 if the FIFO was empty.
- Throughput is one packet per cycle with `gin_ready`=1 continuously.
- While `gin_enable`=1 and `gin_ready`=0, `data_packet` is held stable.
- `gin_enable` never depends combinationally on `gin_ready`.
- Simultaneous push and pop at full FIFO: allowed only if `in_ready` was 1, so full means no push. Push and pop in the same cycle keep the count unchanged.
- The counter reaching `SCAN_LEN`: `cfg_ready` is 0 from the next cycle. Extra `cfg_valid` is never accepted.
- Reset mid-PROGRAM or mid-RUN: outputs return to reset values at the next edge and FIFO contents are discarded. The GIN scan-chain contents are undefined; software must reprogram.

## Structure
- Shared package `gin_pkg`:
  - `INPUT_PACKET_LENGTH = 2*TAG_LENGTH+BITWIDTH`.
  - `SCAN_LEN` function.
  - State encoding UNPROG=0, PROGRAM=1, RUN=2.
- Sub-module `gin_sender_fifo`:
  - Synchronous FIFO, `FIFO_DEPTH` × `INPUT_PACKET_LENGTH`.
  - Registered head.
  - Outputs: `full`, `empty`.
- Top contains the FSM, shift counter, pending flag and output registers.

## Test plan
- Program with tags 0,0,0,0,0,1,2,3,1,2,3,4,2,3,4,5,3,4,5,6 (index order 19..0), `cfg_valid` continuous → `program` high exactly 20 consecutive cycles, `scan_tag_out` sequence identical, `programmed`=1 after cycle 20.
- Same programming with `cfg_valid` low for 3 cycles after word 7 → `program` low for exactly those 3 cycles, 20 total high cycles, GIN tag IDs match the loaded values.
- RUN, `gin_ready`=1, send row 0 col 0..6 data 65535 back-to-back → `data_packet` = {0,col,16'hFFFF} on 7 consecutive cycles starting 1 cycle after the first accept; PE values match GIN tag map.
- `gin_ready`=0 for 6 cycles while inputs are offered → head held, FIFO fills to 4, `in_ready`=0; releasing `gin_ready` drains 4 packets in order with no loss.
- `start_program` with 3 packets queued → `in_ready`=0 next cycle, 3 packets delivered, then PROGRAM entered with `cfg_ready`=1.
- `rstb`=0 after 9 shifted tags → next edge all outputs 0, state UNPROG; `start_program` followed by 20 tags completes a clean program.
